// File: rtl/md_pkg.sv
// md_pkg: shared definitions for the multiply/divide unit.
//   - md_op encodings (MD_MULT, MD_MULTU, MD_DIV, MD_DIVU)
//   - FSM state type and values (IDLE, RUN)
//   - busy-cycle counter width
package md_pkg;

  localparam int unsigned CntW = 5;

  typedef logic [1:0] md_op_t;

  localparam md_op_t MD_MULT  = 2'b00;
  localparam md_op_t MD_MULTU = 2'b01;
  localparam md_op_t MD_DIV   = 2'b10;
  localparam md_op_t MD_DIVU  = 2'b11;

  typedef logic [0:0] md_state_t;

  localparam md_state_t IDLE = 1'b0;
  localparam md_state_t RUN  = 1'b1;

endpackage

// File: rtl/md_calc.sv
// md_calc: combinational multiply/divide datapath.
// Ports:
//   op       in  2   latched operation (md_op_t encoding)
//   a, b     in  32  latched rs / rt operands
//   result   out 64  {hi, lo} result
//   div_zero out 1   divide operation with b == 0 (result must not be committed)
module md_calc
  import md_pkg::*;
(
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] result,
  output logic        div_zero
);

  logic signed [63:0] s_prod;
  logic        [63:0] u_prod;
  // Signed divide is done 33 bits wide so 0x80000000 / -1 does not overflow;
  // the low 32 bits of the quotient then give 0x80000000.
  logic signed [32:0] s_num;
  logic signed [32:0] s_den;
  logic signed [32:0] s_quo;
  logic signed [32:0] s_rem;
  logic        [31:0] u_den;
  logic        [31:0] u_quo;
  logic        [31:0] u_rem;
  logic               unused_bits;

  assign div_zero = op[1] && (b == 32'd0);

  assign s_prod = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign u_prod = {32'd0, a} * {32'd0, b};

  // Divisor forced to 1 on divide-by-zero to keep the datapath X-free;
  // the result is discarded in that case anyway.
  assign s_num = $signed({a[31], a});
  assign s_den = (b == 32'd0) ? 33'sd1 : $signed({b[31], b});
  assign s_quo = s_num / s_den;
  assign s_rem = s_num % s_den;

  assign u_den = (b == 32'd0) ? 32'd1 : b;
  assign u_quo = a / u_den;
  assign u_rem = a % u_den;

  assign unused_bits = ^{s_quo[32], s_rem[32]};

  always_comb begin
    result = 64'd0;
    unique case (op)
      MD_MULT:  result = s_prod;
      MD_MULTU: result = u_prod;
      MD_DIV:   result = {s_rem[31:0], s_quo[31:0]};
      MD_DIVU:  result = {u_rem, u_quo};
      default:  result = 64'd0;
    endcase
  end

endmodule

// File: rtl/md_unit.sv
// md_unit: E-stage multiply/divide unit with architectural HI/LO registers.
// Accepts a one-cycle start pulse, holds busy for MULT_CYCLES / DIV_CYCLES, then
// commits the result to HI/LO. Also services MTHI/MTLO writes while idle.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start, md_op        launch operation (00 MULT, 01 MULTU, 10 DIV, 11 DIVU)
//   a, b                rs / rt operands, latched on start
//   mt_we, mt_sel       MT write enable, 0 = LO, 1 = HI
//   mt_data             MT write data
//   cancel              (only with MD_CANCEL_EN) flush in-flight op / drop start and MT
//   busy                operation in flight (registered)
//   hi, lo              architectural HI / LO registers
// Build option: define MD_CANCEL_EN to add the cancel input.
module md_unit
  import md_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,  // 1..31
  parameter int unsigned DIV_CYCLES  = 10  // 1..31
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  md_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        mt_we,
  input  logic        mt_sel,
  input  logic [31:0] mt_data,
`ifdef MD_CANCEL_EN
  input  logic        cancel,
`endif
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [CntW-1:0] MultCnt = CntW'(MULT_CYCLES);
  localparam logic [CntW-1:0] DivCnt  = CntW'(DIV_CYCLES);

  md_state_t       state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  md_op_t          op_q, op_d;
  logic [31:0]     a_q, a_d;
  logic [31:0]     b_q, b_d;
  logic [31:0]     hi_q, hi_d;
  logic [31:0]     lo_q, lo_d;

  logic [63:0]     result;
  logic            div_zero;
  logic            cancel_req;

`ifdef MD_CANCEL_EN
  assign cancel_req = cancel;
`else
  assign cancel_req = 1'b0;
`endif

  // Operates only on latched operands so live a/b may change during RUN.
  md_calc u_calc (
    .op       (op_q),
    .a        (a_q),
    .b        (b_q),
    .result   (result),
    .div_zero (div_zero)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      IDLE: begin
        if (cancel_req) begin
          // Flush drops both a start and an MT write in this cycle.
        end else if (start) begin
          state_d = RUN;
          cnt_d   = md_op[1] ? DivCnt : MultCnt;
          op_d    = md_op;
          a_d     = a;
          b_d     = b;
        end else if (mt_we) begin
          if (mt_sel) hi_d = mt_data;
          else        lo_d = mt_data;
        end
      end
      RUN: begin
        if (cancel_req) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CntW'(1)) begin
          state_d = IDLE;
          cnt_d   = '0;
          if (!div_zero) begin
            hi_d = result[63:32];
            lo_d = result[31:0];
          end
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= MD_MULT;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy = (state_q == RUN);
  assign hi   = hi_q;
  assign lo   = lo_q;

`ifndef SYNTHESIS
  // The stall controller must never issue a start while busy.
  start_while_busy: assert property (@(posedge clk) disable iff (!rst_n) !(start && busy));
`endif

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: stimulus pushes expected HI/LO and busy length
// into a scoreboard queue; a monitor pops and compares when busy drops.
module tb_md_unit;

  localparam int unsigned MC = 5;
  localparam int unsigned DC = 10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  md_op = 2'b00;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        mt_we = 1'b0;
  logic        mt_sel = 1'b0;
  logic [31:0] mt_data = '0;
`ifdef MD_CANCEL_EN
  logic        cancel = 1'b0;
`endif
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  md_unit #(
    .MULT_CYCLES (MC),
    .DIV_CYCLES  (DC)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .md_op   (md_op),
    .a       (a),
    .b       (b),
    .mt_we   (mt_we),
    .mt_sel  (mt_sel),
    .mt_data (mt_data),
`ifdef MD_CANCEL_EN
    .cancel  (cancel),
`endif
    .busy    (busy),
    .hi      (hi),
    .lo      (lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cycles;
    string       name;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          passes = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
  endtask

  // Reference model: architectural effect of an op on HI/LO.
  function automatic void model_op(input logic [1:0] op, input logic [31:0] x,
                                   input logic [31:0] y);
    longint          sx, sy, sp, sq, sr;
    longint unsigned ux, uy, up, uq, ur;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'd0, x};
    uy = {32'd0, y};
    case (op)
      2'b00: begin sp = sx * sy; m_hi = sp[63:32]; m_lo = sp[31:0]; end
      2'b01: begin up = ux * uy; m_hi = up[63:32]; m_lo = up[31:0]; end
      2'b10: if (y != 0) begin
        sq = sx / sy; sr = sx % sy; m_hi = sr[31:0]; m_lo = sq[31:0];
      end
      default: if (y != 0) begin
        uq = ux / uy; ur = ux % uy; m_hi = ur[31:0]; m_lo = uq[31:0];
      end
    endcase
  endfunction

  // Monitor: counts busy cycles and checks HI/LO when an op retires.
  initial begin
    int   bcnt;
    bit   prev;
    exp_t e;
    bcnt = 0;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        bcnt = 0;
        prev = 1'b0;
      end else if (busy) begin
        bcnt++;
        prev = 1'b1;
      end else if (prev) begin
        prev = 1'b0;
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_result: busy fell with empty scoreboard, hi=0x%0h lo=0x%0h",
                   hi, lo);
        end else begin
          e = exp_q.pop_front();
          check({e.name, "_busy_cycles"}, 64'(bcnt), 64'(e.cycles));
          check({e.name, "_hi"}, {32'd0, hi}, {32'd0, e.hi});
          check({e.name, "_lo"}, {32'd0, lo}, {32'd0, e.lo});
        end
        bcnt = 0;
      end
    end
  end

  task automatic wait_idle();
    int t;
    t = 0;
    while (busy && t < 64) begin
      @(posedge clk); #1;
      t++;
    end
    if (busy) begin
      checks++;
      $display("FAIL wait_idle: busy still 1 after %0d cycles, expected 0", t);
    end
  endtask

  task automatic mt_write(input logic sel, input logic [31:0] data, input string name);
    wait_idle();
    mt_we = 1'b1; mt_sel = sel; mt_data = data;
    if (sel) m_hi = data;
    else     m_lo = data;
    @(posedge clk); #1;
    mt_we = 1'b0;
    check({name, "_hi"}, {32'd0, hi}, {32'd0, m_hi});
    check({name, "_lo"}, {32'd0, lo}, {32'd0, m_lo});
  endtask

  // Issues one op; during busy the live inputs are scrambled and MT writes attempted.
  task automatic issue(input logic [1:0] op, input logic [31:0] x, input logic [31:0] y,
                       input bit with_mt, input string name);
    exp_t e;
    int   n;
    wait_idle();
    n = op[1] ? DC : MC;
    start = 1'b1; md_op = op; a = x; b = y;
    if (with_mt) begin
      mt_we = 1'b1; mt_sel = 1'($urandom_range(0, 1)); mt_data = $urandom;
    end
    model_op(op, x, y);
    e.hi = m_hi; e.lo = m_lo; e.cycles = n; e.name = name;
    exp_q.push_back(e);
    @(posedge clk); #1;
    start = 1'b0; mt_we = 1'b0;
    for (int k = 1; k < n; k++) begin
      a = $urandom; b = $urandom; md_op = 2'($urandom);
      mt_we = 1'($urandom_range(0, 1)); mt_sel = 1'($urandom_range(0, 1)); mt_data = $urandom;
      @(posedge clk); #1;
    end
    mt_we = 1'b0;
  endtask

  initial begin
    logic [1:0]  op;
    logic [31:0] x;
    logic [31:0] y;

    #3;
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_hi", {32'd0, hi}, 64'd0);
    check("reset_lo", {32'd0, lo}, 64'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    issue(2'b00, 32'hFFFF_FFFE, 32'd3, 1'b0, "mult_neg2x3");
    issue(2'b01, 32'hFFFF_FFFE, 32'd3, 1'b0, "multu_big_x3");
    issue(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0, "div_m7_2");
    issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "div_overflow");
    mt_write(1'b1, 32'h11, "mthi_11");
    mt_write(1'b0, 32'h22, "mtlo_22");
    issue(2'b11, 32'd5, 32'd0, 1'b0, "divu_by_zero");
    issue(2'b10, 32'd7, 32'd0, 1'b0, "div_by_zero");
    mt_write(1'b1, 32'h1234, "mthi_1234");
    issue(2'b00, 32'd6, 32'd7, 1'b1, "start_with_mt");

    for (int i = 0; i < 30; i++) begin
      op = 2'($urandom);
      x = $urandom;
      y = $urandom;
      case ($urandom_range(0, 7))
        0: y = 32'd0;
        1: y = 32'($urandom_range(1, 9));
        2: y = 32'hFFFF_FFFF;
        3: x = 32'h8000_0000;
        default: ;
      endcase
      if ($urandom_range(0, 3) == 0) mt_write(1'($urandom_range(0, 1)), $urandom, "rand_mt");
      issue(op, x, y, 1'($urandom_range(0, 1)), "rand_op");
    end

    // Asynchronous reset in the middle of a DIV.
    wait_idle();
    start = 1'b1; md_op = 2'b10; a = 32'd100; b = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b0;
    exp_q.delete();
    m_hi = '0; m_lo = '0;
    #1;
    check("midop_reset_busy", {63'd0, busy}, 64'd0);
    check("midop_reset_hi", {32'd0, hi}, 64'd0);
    check("midop_reset_lo", {32'd0, lo}, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    issue(2'b01, 32'd9, 32'd9, 1'b0, "after_reset_multu");

`ifdef MD_CANCEL_EN
    begin
      exp_t e;
      wait_idle();
      start = 1'b1; md_op = 2'b10; a = 32'd1000; b = 32'd7;
      e.hi = m_hi; e.lo = m_lo; e.cycles = 4; e.name = "cancel_div";
      exp_q.push_back(e);
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      cancel = 1'b1;
      @(posedge clk); #1;
      cancel = 1'b0;
      check("cancel_busy_next", {63'd0, busy}, 64'd0);
      start = 1'b1; cancel = 1'b1; md_op = 2'b00; a = 32'd3; b = 32'd3;
      @(posedge clk); #1;
      start = 1'b0; cancel = 1'b0;
      check("cancel_with_start", {63'd0, busy}, 64'd0);
      mt_we = 1'b1; mt_sel = 1'b1; mt_data = ~m_hi; cancel = 1'b1;
      @(posedge clk); #1;
      mt_we = 1'b0; cancel = 1'b0;
      check("cancel_with_mt", {32'd0, hi}, {32'd0, m_hi});
    end
`endif

    wait_idle();
    @(posedge clk); @(posedge clk); #1;
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, passed %0d of %0d", passes, checks);
    $fatal(1);
  end

endmodule

// File: doc/md_unit.md
# md_unit

Multiply/divide unit for the E stage of the five-stage MIPS pipeline. It accepts a one-cycle `start` pulse for MULT/MULTU/DIV/DIVU and holds `busy` for a fixed number of cycles, then commits the result to HI/LO. It also performs MTHI/MTLO writes and drives HI/LO to the MFHI/MFLO datapath. It is the responder side of the `start`/`busy` handshake that the hazard/stall controller monitors.

## Interface
- `MULT_CYCLES`, default 5: busy cycles for MULT/MULTU, legal range 1..31.
- `DIV_CYCLES`, default 10: busy cycles for DIV/DIVU, legal range 1..31.
- `clk` in 1: the single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start` in 1: launch the operation in `md_op`, one-cycle pulse.
- `md_op` in 2: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled only when `start`=1.
- `a` in 32: rs operand.
- `b` in 32: rt operand.
- `mt_we` in 1: MTHI/MTLO write enable.
- `mt_sel` in 1: 0 writes LO, 1 writes HI.
- `mt_data` in 32: write data.
- `busy` out 1: operation in flight.
- `hi` out 32: architectural HI register.
- `lo` out 32: architectural LO register.

## Operation
- FSM states:
  - IDLE → RUN on `start`. The operands and op are latched, and the counter loads MULT_CYCLES or DIV_CYCLES.
  - RUN: the counter decrements each cycle. When the counter reaches 1, the result is written to HI/LO and the FSM returns to IDLE.
- `busy` equals (state == RUN). It is registered and has no combinational path from `start`.
- Multiply:
  - MULT: 64-bit signed product of `a` and `b`.
  - MULTU: 64-bit unsigned product.
  - HI receives the upper 32 bits and LO the lower 32 bits.
- Divide:
  - LO receives the quotient truncated toward zero. HI receives the remainder, which takes the sign of the dividend.
  - DIV 0x80000000 / 0xFFFFFFFF gives LO=0x80000000 and HI=0.
  - Divide by zero, signed or unsigned: full busy period, then HI and LO are left unchanged.
- The result is computed from the latched operands, never from live `a`/`b`.
- `start` while `busy`=1 is ignored. The controller guarantees this does not happen; the assertion build flags it.
- `mt_we` while `busy`=1 is ignored.
- `mt_we` together with `start` in the same cycle: `start` wins and the MT write is dropped.
- `mt_we` while idle writes the selected register at the next edge. The other register is unchanged.

## Timing
- Reset values: `busy`=0, `hi`=0, `lo`=0, state IDLE, counter 0. Reset takes effect immediately (asynchronous), including mid-operation; the in-flight op is lost.
- Start-to-result:
  - `start` sampled at edge T.
  - `busy`=1 during cycles T+1 through T+N, where N is the op's cycle count.
  - HI/LO are updated at the edge ending cycle T+N.
  - In cycle T+N+1, `busy`=0 and the new HI/LO are visible.
- Back-to-back: a new `start` is accepted in the first cycle that `busy`=0.
- MT writes are visible on `hi`/`lo` one cycle after `mt_we`.
- `hi`/`lo` are direct register outputs with no bypass.

## Configuration
- `MD_CANCEL_EN`, when defined:
  - Adds input `cancel` (1 bit), used for exception/interrupt flush of the E stage.
  - `cancel`=1 in RUN: state returns to IDLE, `busy`=0 next cycle, HI/LO unchanged.
  - `cancel` together with `start`: the start is discarded.
  - `cancel` together with `mt_we`: the write is discarded.
- Without the macro there is no `cancel` port, and every accepted operation runs to completion.

## Structure
- The shared package `md_pkg` holds:
  - the `md_op` encodings (MD_MULT, MD_MULTU, MD_DIV, MD_DIVU);
  - the FSM state typedef (IDLE, RUN);
  - the counter width constant (5 bits).
- Sub-module `md_calc`: combinational. It takes the latched op, a and b, and produces a 64-bit {hi,lo} result plus a div-by-zero flag. `md_unit` keeps the FSM, counter and HI/LO registers.

## Test plan
- MULT a=0xFFFFFFFE, b=3 → `busy` high exactly 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- MULTU a=0xFFFFFFFE, b=3 → hi=0x00000002, lo=0xFFFFFFFA.
- DIV a=0xFFFFFFF9 (−7), b=2 → `busy` high 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF. Changing `a`/`b` during busy does not alter the result.
- DIVU a=5, b=0 with hi=0x11, lo=0x22 beforehand → `busy` high 10 cycles, then hi=0x11, lo=0x22.
- Idle, mt_we=1, mt_sel=1, mt_data=0x1234 → hi=0x1234 next cycle, lo unchanged. Then start plus mt_we in the same cycle → MT dropped and the op completes normally.
- `rst_n` low in cycle 3 of a DIV → busy=0, hi=0, lo=0 immediately. With `MD_CANCEL_EN`: `cancel` in cycle 4 → busy=0 next cycle and HI/LO keep their prior values.
